coin_accumulator: RTL and testbench

COIN_ACCUMULATOR -- requirements
Module: coin_accumulator

---
 rtl/coin_accumulator.sv | 156 +++++++++++++++
 tb/tb_coin_accumulator.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/coin_accumulator.sv
// Coin credit accumulator for a vending machine: sums accepted coins, rejects overflow/locked
// coins, and pays out the full credit on user cancel or on an inactivity timeout.
module coin_accumulator #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_VALUE      = 127
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_coin_valid,
    input  logic [1:0] i_coin_type,
    input  logic       i_lock,
    input  logic       i_clear,
    input  logic       i_refund_req,
    output logic [6:0] o_total_coin_value,
    output logic       o_coin_reject,
    output logic       o_refund_valid,
    output logic [6:0] o_refund_value,
    output logic [1:0] o_state
);

    localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      MAX_V    = 8'(MAX_VALUE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_REFUND  = 2'd3
    } state_t;

    function automatic logic [7:0] coin_value(input logic [1:0] coin_type);
        logic [7:0] v;
        case (coin_type)
            2'b00:   v = 8'd5;
            2'b01:   v = 8'd10;
            2'b10:   v = 8'd20;
            2'b11:   v = 8'd50;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    state_t          state_r, state_s;
    logic [6:0]      total_r, total_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            reject_r, reject_s;
    logic            refund_valid_r;
    logic [6:0]      refund_value_r;
    logic [7:0]      sum_s;
    logic            fits_s;

    // Next-state, credit and timeout logic; priority clear > refund > lock > coin > timeout.
    always_comb begin
        state_s  = state_r;
        total_s  = total_r;
        cnt_s    = cnt_r;
        reject_s = 1'b0;
        // Eight-bit sum so an overflowing coin is detected instead of wrapping.
        sum_s    = {1'b0, total_r} + coin_value(i_coin_type);
        fits_s   = (sum_s <= MAX_V);
        case (state_r)
            ST_IDLE: begin
                if (i_clear) begin
                    reject_s = i_coin_valid;
                end else if (i_refund_req) begin
                    state_s  = ST_REFUND;
                    reject_s = i_coin_valid;
                end else if (i_lock) begin
                    state_s  = ST_LOCKED;
                    total_s  = 7'd0;
                    reject_s = i_coin_valid;
                end else if (i_coin_valid && fits_s) begin
                    state_s = ST_COLLECT;
                    total_s = sum_s[6:0];
                    cnt_s   = {CW{1'b0}};
                end else begin
                    reject_s = i_coin_valid;
                end
            end
            ST_COLLECT: begin
                if (i_clear) begin
                    state_s  = ST_IDLE;
                    total_s  = 7'd0;
                    reject_s = i_coin_valid;
                end else if (i_refund_req) begin
                    state_s  = ST_REFUND;
                    reject_s = i_coin_valid;
                end else if (i_lock) begin
                    state_s  = ST_LOCKED;
                    reject_s = i_coin_valid;
                end else if (i_coin_valid && fits_s) begin
                    total_s = sum_s[6:0];
                    cnt_s   = {CW{1'b0}};
                end else begin
                    reject_s = i_coin_valid;
                    if (cnt_r == CNT_LAST) begin
                        state_s = ST_REFUND;
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end
            end
            ST_LOCKED: begin
                reject_s = i_coin_valid;
                if (i_clear) begin
                    state_s = ST_IDLE;
                    total_s = 7'd0;
                end else if (i_refund_req) begin
                    state_s = ST_REFUND;
                end else if (!i_lock) begin
                    state_s = ST_COLLECT;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = ST_LOCKED;
                end
            end
            ST_REFUND: begin
                reject_s = i_coin_valid;
                state_s  = ST_IDLE;
                total_s  = 7'd0;
            end
            default: begin
                state_s = ST_IDLE;
                total_s = 7'd0;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, credit and registered output flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r        <= ST_IDLE;
            total_r        <= 7'd0;
            cnt_r          <= {CW{1'b0}};
            reject_r       <= 1'b0;
            refund_valid_r <= 1'b0;
            refund_value_r <= 7'd0;
        end else begin
            state_r        <= state_s;
            total_r        <= total_s;
            cnt_r          <= cnt_s;
            reject_r       <= reject_s;
            refund_valid_r <= (state_s == ST_REFUND);
            refund_value_r <= (state_s == ST_REFUND) ? total_s : 7'd0;
        end
    end

    assign o_total_coin_value = total_r;
    assign o_coin_reject      = reject_r;
    assign o_refund_valid     = refund_valid_r;
    assign o_refund_value     = refund_value_r;
    assign o_state            = state_r;

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed self-checking bench for coin_accumulator with a 16-cycle timeout.
module tb_coin_accumulator;

    logic       clk;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       lock;
    logic       clear;
    logic       refund_req;
    logic [6:0] total;
    logic       coin_reject;
    logic       refund_valid;
    logic [6:0] refund_value;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    coin_accumulator #(.TIMEOUT_CYCLES(16), .MAX_VALUE(127)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_coin_valid       (coin_valid),
        .i_coin_type        (coin_type),
        .i_lock             (lock),
        .i_clear            (clear),
        .i_refund_req       (refund_req),
        .o_total_coin_value (total),
        .o_coin_reject      (coin_reject),
        .o_refund_valid     (refund_valid),
        .o_refund_value     (refund_value),
        .o_state            (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // coin types: 0=5, 1=10, 2=20, 3=50
    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        step();
        coin_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int st, input int tot, input int rej,
                              input int rv, input int rval);
        check({tag, ".state"},  32'(state),        32'(st));
        check({tag, ".total"},  32'(total),        32'(tot));
        check({tag, ".reject"}, 32'(coin_reject),  32'(rej));
        check({tag, ".rvalid"}, 32'(refund_valid), 32'(rv));
        check({tag, ".rvalue"}, 32'(refund_value), 32'(rval));
    endtask

    initial begin
        rst_n = 1'b0; coin_valid = 1'b0; coin_type = 2'd0;
        lock = 1'b0; clear = 1'b0; refund_req = 1'b0;
        idle(2);
        expect_out("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Basic accumulation
        coin(2'd3); expect_out("c50", 1, 50, 0, 0, 0);
        coin(2'd1); expect_out("c10", 1, 60, 0, 0, 0);

        // Overflow reject and boundary
        coin(2'd2); coin(2'd2); expect_out("to100", 1, 100, 0, 0, 0);
        coin(2'd3); expect_out("ovf50", 1, 100, 1, 0, 0);
        step();     expect_out("ovf_after", 1, 100, 0, 0, 0);
        coin(2'd2); expect_out("add20", 1, 120, 0, 0, 0);
        coin(2'd0); expect_out("add5_125", 1, 125, 0, 0, 0);
        coin(2'd0); expect_out("ovf5_130", 1, 125, 1, 0, 0);

        // User refund
        refund_req = 1'b1; step(); refund_req = 1'b0;
        expect_out("refund", 3, 125, 0, 1, 125);
        step(); expect_out("refund_done", 0, 0, 0, 0, 0);

        // Lock, rejected coin, clear
        coin(2'd3); coin(2'd1);
        lock = 1'b1; step(); expect_out("locked", 2, 60, 0, 0, 0);
        coin(2'd0); expect_out("lock_coin", 2, 60, 1, 0, 0);
        clear = 1'b1; step(); clear = 1'b0; lock = 1'b0;
        expect_out("lock_clear", 0, 0, 0, 0, 0);
        clear = 1'b1; step(); clear = 1'b0;
        expect_out("idle_clear", 0, 0, 0, 0, 0);

        // Inactivity timeout
        coin(2'd2); coin(2'd1); expect_out("to30", 1, 30, 0, 0, 0);
        idle(15); expect_out("pre_timeout", 1, 30, 0, 0, 0);
        step();   expect_out("timeout", 3, 30, 0, 1, 30);
        step();   expect_out("timeout_done", 0, 0, 0, 0, 0);

        // Coin on the last counter cycle wins
        coin(2'd0); idle(15);
        coin(2'd1); expect_out("coin_wins", 1, 15, 0, 0, 0);
        idle(15); expect_out("restart_pre", 1, 15, 0, 0, 0);
        step();   expect_out("restart_to", 3, 15, 0, 1, 15);
        step();

        // Refund from IDLE gives zero-value pulse
        refund_req = 1'b1; step(); refund_req = 1'b0;
        expect_out("idle_refund", 3, 0, 0, 1, 0);
        step();

        // Coin in the same cycle as refund request is rejected
        coin(2'd0);
        refund_req = 1'b1; coin(2'd3); refund_req = 1'b0;
        expect_out("coin_w_refund", 3, 5, 1, 1, 5);
        step();

        // Lock from IDLE, release into COLLECT
        lock = 1'b1; step(); expect_out("idle_lock", 2, 0, 0, 0, 0);
        lock = 1'b0; step(); expect_out("unlock", 1, 0, 0, 0, 0);
        clear = 1'b1; step(); clear = 1'b0;

        // Reset mid-transaction
        coin(2'd3); coin(2'd2); expect_out("to70", 1, 70, 0, 0, 0);
        rst_n = 1'b0; #1;
        expect_out("async_rst", 0, 0, 0, 0, 0);
        idle(3); expect_out("rst_hold", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        coin(2'd0); expect_out("post_rst", 1, 5, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
